// File: rtl/muldiv_pkg.sv
// Shared constants, RV32M funct3 encodings and FSM state encoding for the
// iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = neg ? -in : in.
// Used for operand magnitudes and for the final sign correction.
module muldiv_negate
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] in,
    input  logic            neg,
    output logic [XLEN-1:0] out
);

    assign out = neg ? (~in + 32'd1) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, followed by a single sign-correction cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output state_t          fsm_state
);

    // Handshake: start is taken on any rising edge where busy==0 (IDLE or
    // DONE); operands are captured on that edge. done pulses for one cycle
    // with result valid, and result holds until the next accepted op
    // completes its FIX cycle.

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic              spec_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_val;
    logic              neg_next;

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign fsm_state = state_q;
    assign accept    = start && !busy;

    assign signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sign_a   = signed_a && rs1_val[XLEN-1];
    assign sign_b   = signed_b && rs2_val[XLEN-1];

    muldiv_negate u_neg_a (.in(rs1_val), .neg(sign_a), .out(mag_a));
    muldiv_negate u_neg_b (.in(rs2_val), .neg(sign_b), .out(mag_b));

    // Divide-by-zero and signed overflow bypass CALC with a fixed answer.
    assign div_zero = funct3[2] && (rs2_val == '0);
    assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;
    assign neg_next = (funct3 == F3_REM) ? sign_a : (sign_a ^ sign_b);

    always_comb begin
        spec_val = '0;
        if (div_zero)
            spec_val = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_val = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}.
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    assign div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
    assign div_diff = acc_q[2*XLEN-2:XLEN-1] - b_q;
    assign div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                             : {acc_q[2*XLEN-2:0], 1'b0};

    // FIX stage: a 64-bit negation's high word is ~hi unless lo is zero.
    logic [XLEN-1:0] fix_in, fix_out, fix_val;
    logic            fix_neg, invert_hi;
    logic [XLEN-1:0] acc_lo, acc_hi;
    assign acc_lo = acc_q[XLEN-1:0];
    assign acc_hi = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_in    = acc_lo;
        fix_neg   = neg_q;
        invert_hi = 1'b0;
        if (spec_q) begin
            fix_neg = 1'b0;
        end else begin
            case (op_q)
                F3_MULH, F3_MULHSU, F3_MULHU: begin
                    fix_in    = acc_hi;
                    invert_hi = neg_q && (acc_lo != '0);
                end
                F3_REM, F3_REMU: fix_in = acc_hi;
                default:         fix_in = acc_lo;
            endcase
        end
    end

    muldiv_negate u_neg_fix (.in(fix_in), .neg(fix_neg), .out(fix_out));
    assign fix_val = invert_hi ? ~acc_hi : fix_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = special ? FIX : CALC;
                else
                    state_d = IDLE;
            end
            CALC:    if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= funct3;
                b_q    <= mag_b;
                acc_q  <= {{XLEN{1'b0}}, special ? spec_val : mag_a};
                neg_q  <= neg_next;
                spec_q <= special;
                cnt_q  <= '0;
            end else if (state_q == CALC) begin
                acc_q <= op_q[2] ? div_next : mul_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIX)
                result_q <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, all eight ops, special divides,
// ignored start, mid-op abort and back-to-back issue from DONE.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        busy, done;
    logic [31:0] result;
    state_t      fsm_state;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy), .done(done),
        .result(result), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Driver: issue one op, sample on negedges; count k=1 is the first
    // sample after the accepting edge. Stops at the first done or after 40.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int done_at, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b;
        done_at = 0; busy_cycles = 0; res = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_at = k; res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; funct3 = F3_MUL; rs1_val = 32'd7; rs2_val = 32'd3;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++;
        if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", result); end
        tests_run++;
        if (fsm_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int d, bc;
        run_op(F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, r, d, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_result: got %h want ffffffeb", r); end
        tests_run++;
        if (d !== 34) begin tests_failed++; $display("FAIL mul_done_edge: got %0d want 34", d); end
        tests_run++;
        if (bc !== 33) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL mul_done_pulse: got %b want 0", done); end
        tests_run++;
        if (result !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_result_hold: got %h want ffffffeb", result); end
    endtask

    task automatic test_mulh();
        logic [2:0]  fs[3]  = '{F3_MULH, F3_MULHU, F3_MULHSU};
        logic [31:0] as[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] r; int d, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(fs[i], as[i], bs[i], r, d, bc);
            tests_run++;
            if (r !== exp[i] || d !== 34) begin
                tests_failed++;
                $display("FAIL mulh_%0d: got %h at %0d want %h at 34", i, r, d, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs[4]  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r; int d, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], r, d, bc);
            tests_run++;
            if (r !== exp[i] || d !== 34) begin
                tests_failed++;
                $display("FAIL div_%0d: got %h at %0d want %h at 34", i, r, d, exp[i]);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  fs[6]  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
        logic [31:0] as[6]  = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                                32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[6] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678,
                                32'h8000_0000, 32'h0};
        logic [31:0] r; int d, bc;
        for (int i = 0; i < 6; i++) begin
            run_op(fs[i], as[i], bs[i], r, d, bc);
            tests_run++;
            if (r !== exp[i] || d !== 2 || bc !== 1) begin
                tests_failed++;
                $display("FAIL div_special_%0d: got %h at %0d busy %0d want %h at 2 busy 1",
                         i, r, d, bc, exp[i]);
            end
        end
    endtask

    task automatic test_ignore_and_abort();
        int d; int seen;
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; rs1_val = 32'd100; rs2_val = 32'd7;
        d = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin funct3 = F3_MUL; rs1_val = 32'd3; rs2_val = 32'd5; end
            if (done) begin d = k; break; end
        end
        start = 1'b0;
        tests_run++;
        if (result !== 32'd14 || d !== 34) begin
            tests_failed++;
            $display("FAIL ignore_start: got %h at %0d want 0000000e at 34", result, d);
        end
        @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; rs1_val = 32'd9; rs2_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || result !== 32'h0 || fsm_state !== IDLE) begin
            tests_failed++;
            $display("FAIL abort_state: busy %b result %h state %0d want 0 00000000 IDLE",
                     busy, result, fsm_state);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || result !== 32'h0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int d, bc;
        run_op(F3_REMU, 32'd100, 32'd7, r, d, bc);
        tests_run++;
        if (r !== 32'd2 || d !== 34) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h at %0d want 00000002 at 34", r, d);
        end
        start = 1'b1; funct3 = F3_MUL; rs1_val = 32'h0000_0007; rs2_val = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        d = 0; r = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin d = k; r = result; break; end
        end
        tests_run++;
        if (r !== 32'hFFFF_FFEB || d !== 34) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h at %0d want ffffffeb at 34", r, d);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_ignore_and_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port funct3, input, 3 bits: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_val, input, 32 bits: operand A (register-file rd1).
REQ-007 SHALL have port rs2_val, input, 32 bits: operand B (register-file rd2).
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32 bits: writeback value for the register file.

Function
REQ-011 SHALL use FSM states IDLE, CALC, FIX, DONE; busy SHALL be 1 in CALC and FIX only.
REQ-012 SHALL accept start only when busy==0 (IDLE or DONE), which allows back-to-back operation from DONE.
REQ-013 SHALL capture funct3, rs1_val and rs2_val on the accepting edge; later input changes SHALL have no effect.
REQ-014 SHALL ignore start while busy==1.
REQ-015 SHALL, for a normal op, run CALC for exactly 32 iterations (one per cycle), then FIX for 1 cycle, then DONE for 1 cycle.
REQ-016 SHALL raise done on the 34th rising edge after the accepting edge, for exactly one cycle.
REQ-017 SHALL drive the final value on result while done==1 and hold it until the next accepted start.
REQ-018 Multiply SHALL be shift-add on operand magnitudes into a 64-bit product, negated in FIX when the effective signs differ.
REQ-019 Multiply signedness SHALL be: MUL/MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
REQ-020 Multiply output SHALL be product[31:0] for MUL and product[63:32] otherwise.
REQ-021 Divide SHALL be restoring division on magnitudes.
REQ-022 Signed quotient SHALL be negated when operand signs differ.
REQ-023 Signed remainder SHALL take the sign of the dividend, and the quotient SHALL truncate toward zero.
REQ-024 SHALL detect divide-by-zero (rs2_val==0) on the accepting edge and skip CALC (IDLE->FIX->DONE), raising done on the 2nd edge.
REQ-025 Divide-by-zero results SHALL be: quotient 0xFFFFFFFF (DIV and DIVU); remainder = rs1_val (REM and REMU).
REQ-026 SHALL detect signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) and take the same 2-edge path.
REQ-027 Signed overflow results SHALL be: quotient 0x80000000, remainder 0.
REQ-028 SHALL use a 5-bit iteration counter running 0..31 with no wrap into another CALC pass.
REQ-029 SHALL perform all arithmetic modulo 2^32 / 2^64 with no saturation.
REQ-030 A start accepted in DONE SHALL behave identically to one accepted in IDLE, with no extra bubble.

Reset
REQ-031 SHALL, when rst==1 at a rising edge, force IDLE, busy=0, done=0, result=0, counter=0, and clear internal operand/accumulator registers.
REQ-032 rst SHALL take priority over start.
REQ-033 rst mid-operation SHALL abort the operation: no done pulse, and no stale result appears afterwards.

Structure
REQ-034 SHALL place XLEN=32, ITER_COUNT=32, the funct3 op encodings and the FSM state encoding in shared package muldiv_pkg.
REQ-035 SHALL instantiate one sub-module, muldiv_negate (32-bit conditional two's-complement: out = neg ? -in : in), for operand magnitudes and the FIX-stage sign correction.
REQ-036 SHALL sit downstream of the register file read ports and feed result to the writeback mux; it SHALL perform no register-file access itself.

Verification
REQ-037 MUL 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB, done on edge 34, busy high for edges 1-33.
REQ-038 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-039 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-040 DIV 0x12345678 / 0 -> 0xFFFFFFFF and REM -> 0x12345678, done on edge 2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, done on edge 2.
REQ-041 start pulsed at edge 5 of a busy op and operands changed mid-op -> original result unchanged; rst at edge 10 -> busy=0, result=0 after that edge, and no done pulse follows.
REQ-042 New start asserted during the done cycle -> accepted; second done exactly 34 edges later, with the correct second result.
